// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD write controller: power-up init, timed write
// cycles, a one-entry request buffer and a CPU-readable status word.
module lcd_hd44780_ctrl #(
    parameter int T_PWR   = 750000,
    parameter int T_SU    = 3,
    parameter int T_PW    = 13,
    parameter int T_HD    = 3,
    parameter int T_SHORT = 2500,
    parameter int T_LONG  = 100000,
    parameter int CNT_W   = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_reg_i,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        lcd_blon_o,
    output logic [31:0] status_o
);

    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_IDLE  = 3'd5;

    localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0] LD_SU    = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LD_HD    = CNT_W'(T_HD - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

    function automatic logic [7:0] init_cmd(input logic [1:0] s);
        logic [7:0] c;
        case (s)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = 8'h01;
            default: c = 8'h06;
        endcase
        return c;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             cur_rs_q, cur_rs_d;
    logic [7:0]       cur_data_q, cur_data_d;
    logic             pend_v_q, pend_v_d;
    logic             pend_rs_q, pend_rs_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             ovf_q, ovf_d;
    logic             init_done_q, init_done_d;
    logic [1:0]       step_q, step_d;
    logic             go_prev_q, clr_prev_q;
    logic             on_q, blon_q;

    logic go_edge, clr_edge, tmr_done, init_last;
    logic drain, is_long, direct, ovf_set;

    assign go_edge   = lcd_reg_i[10] & ~go_prev_q;
    assign clr_edge  = lcd_reg_i[11] & ~clr_prev_q;
    assign tmr_done  = (timer_q == '0);
    assign init_last = init_done_q | (step_q == 2'd3);
    assign is_long   = ~cur_rs_q & ((cur_data_q == 8'h01) |
                                    (cur_data_q == 8'h02) |
                                    (cur_data_q == 8'h03));
    // Pending leaves the buffer at the end of a post-init WAIT, or from IDLE
    // when a request landed in the buffer on the last WAIT cycle.
    assign drain  = pend_v_q & (((state_q == S_WAIT) & tmr_done & init_last) |
                                (state_q == S_IDLE));
    assign direct = go_edge & (state_q == S_IDLE) & ~pend_v_q;

    // Next-state, timer, transfer and buffer logic
    always_comb begin
        state_d     = state_q;
        timer_d     = tmr_done ? timer_q : timer_q - 1'b1;
        cur_rs_d    = cur_rs_q;
        cur_data_d  = cur_data_q;
        step_d      = step_q;
        init_done_d = init_done_q;
        pend_v_d    = pend_v_q & ~drain;
        pend_rs_d   = pend_rs_q;
        pend_data_d = pend_data_q;
        ovf_set     = 1'b0;

        case (state_q)
            S_PWRUP: if (tmr_done) begin
                state_d    = S_SETUP;
                timer_d    = LD_SU;
                cur_rs_d   = 1'b0;
                cur_data_d = init_cmd(2'd0);
                step_d     = 2'd0;
            end
            S_SETUP: if (tmr_done) begin
                state_d = S_PULSE;
                timer_d = LD_PW;
            end
            S_PULSE: if (tmr_done) begin
                state_d = S_HOLD;
                timer_d = LD_HD;
            end
            S_HOLD: if (tmr_done) begin
                state_d = S_WAIT;
                timer_d = is_long ? LD_LONG : LD_SHORT;
            end
            S_WAIT: if (tmr_done) begin
                if (!init_last) begin
                    state_d    = S_SETUP;
                    timer_d    = LD_SU;
                    step_d     = step_q + 2'd1;
                    cur_rs_d   = 1'b0;
                    cur_data_d = init_cmd(step_q + 2'd1);
                end else begin
                    init_done_d = 1'b1;
                    if (pend_v_q) begin
                        state_d    = S_SETUP;
                        timer_d    = LD_SU;
                        cur_rs_d   = pend_rs_q;
                        cur_data_d = pend_data_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (pend_v_q) begin
                    state_d    = S_SETUP;
                    timer_d    = LD_SU;
                    cur_rs_d   = pend_rs_q;
                    cur_data_d = pend_data_q;
                end else if (go_edge) begin
                    state_d    = S_SETUP;
                    timer_d    = LD_SU;
                    cur_rs_d   = lcd_reg_i[9];
                    cur_data_d = lcd_reg_i[7:0];
                end
            end
            default: begin
                state_d = S_PWRUP;
                timer_d = LD_PWR;
            end
        endcase

        if (go_edge && !direct) begin
            if (!pend_v_q || drain) begin
                pend_v_d    = 1'b1;
                pend_rs_d   = lcd_reg_i[9];
                pend_data_d = lcd_reg_i[7:0];
            end else begin
                ovf_set = 1'b1;
            end
        end

        ovf_d = ovf_set ? 1'b1 : (clr_edge ? 1'b0 : ovf_q);
    end

    // State registers; reset restarts the full power-up sequence
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_PWRUP;
            timer_q     <= LD_PWR;
            cur_rs_q    <= 1'b0;
            cur_data_q  <= 8'h00;
            pend_v_q    <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_data_q <= 8'h00;
            ovf_q       <= 1'b0;
            init_done_q <= 1'b0;
            step_q      <= 2'd0;
            go_prev_q   <= lcd_reg_i[10];
            clr_prev_q  <= lcd_reg_i[11];
            on_q        <= 1'b0;
            blon_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cur_rs_q    <= cur_rs_d;
            cur_data_q  <= cur_data_d;
            pend_v_q    <= pend_v_d;
            pend_rs_q   <= pend_rs_d;
            pend_data_q <= pend_data_d;
            ovf_q       <= ovf_d;
            init_done_q <= init_done_d;
            step_q      <= step_d;
            go_prev_q   <= lcd_reg_i[10];
            clr_prev_q  <= lcd_reg_i[11];
            on_q        <= lcd_reg_i[31];
            blon_q      <= lcd_reg_i[30];
        end
    end

    assign lcd_en_o   = (state_q == S_PULSE);
    assign lcd_rs_o   = cur_rs_q;
    assign lcd_data_o = cur_data_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_on_o   = on_q;
    assign lcd_blon_o = blon_q;
    assign status_o   = {28'd0, init_done_q, ovf_q, pend_v_q,
                         (state_q != S_IDLE) | pend_v_q};

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: directed steps plus random traffic, checked
// every cycle against a transfer-schedule model.
module tb_lcd_hd44780_ctrl;

    localparam int TPWR = 10, TSU = 2, TPW = 4, THD = 2;
    localparam int TSH = 8, TLG = 20;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] lcd_reg_i;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o;
    logic [31:0] status_o;

    lcd_hd44780_ctrl #(
        .T_PWR(TPWR), .T_SU(TSU), .T_PW(TPW), .T_HD(THD),
        .T_SHORT(TSH), .T_LONG(TLG), .CNT_W(20)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .lcd_reg_i(lcd_reg_i),
        .lcd_data_o(lcd_data_o), .lcd_rs_o(lcd_rs_o),
        .lcd_rw_o(lcd_rw_o), .lcd_en_o(lcd_en_o),
        .lcd_on_o(lcd_on_o), .lcd_blon_o(lcd_blon_o),
        .status_o(status_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus
    logic       rst = 1'b1, go = 1'b0, clr = 1'b0, rs = 1'b0;
    logic       on = 1'b0, blon = 1'b0;
    logic [7:0] data = 8'h00;
    logic [18:0] junk = '0;

    // model: one current transfer with start cycle, end of activity, buffer
    int         k, m_end, cur_start;
    bit         cur_v, pv, ovf, idn, mval = 0;
    logic       cur_rs, prs, gp, cp, on_m, blon_m;
    logic [7:0] cur_data, pdata;
    logic [7:0] iq[$];
    int         en_rises = 0;
    logic       en_prev = 1'b0;

    function automatic int dur(input logic r, input logic [7:0] d);
        return TSU + TPW + THD + ((!r && d >= 8'h01 && d <= 8'h03) ? TLG : TSH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input logic r, input logic [7:0] d);
        cur_v = 1; cur_start = k + 1; cur_rs = r; cur_data = d;
        m_end = k + dur(r, d);
    endtask

    task automatic model_check();
        int off;
        logic e_en, e_busy;
        off    = k - cur_start;
        e_en   = cur_v && off >= TSU && off < TSU + TPW;
        e_busy = (k <= m_end) || pv;
        chk("en", {31'd0, lcd_en_o}, {31'd0, e_en});
        chk("rs", {31'd0, lcd_rs_o}, {31'd0, cur_v ? cur_rs : 1'b0});
        chk("data", {24'd0, lcd_data_o}, {24'd0, cur_v ? cur_data : 8'h00});
        chk("rw", {31'd0, lcd_rw_o}, 32'd0);
        chk("on", {31'd0, lcd_on_o}, {31'd0, on_m});
        chk("blon", {31'd0, lcd_blon_o}, {31'd0, blon_m});
        chk("status", status_o, {28'd0, idn, ovf, pv, e_busy});
    endtask

    task automatic model_update();
        bit req, ce, idle, last, drain, nstart, store, oset;
        if (rst) begin
            k = 0; m_end = TPWR - 1; cur_v = 0; cur_start = 0;
            pv = 0; ovf = 0; idn = 0;
            iq = '{8'h38, 8'h0C, 8'h01, 8'h06};
            gp = go; cp = clr; on_m = 0; blon_m = 0; mval = 1;
            return;
        end
        req    = go && !gp;
        ce     = clr && !cp;
        idle   = k > m_end;
        last   = (k == m_end) && iq.size() == 0;
        drain  = pv && (last || idle);
        nstart = req && idle && !pv;
        store  = req && !nstart && (!pv || drain);
        oset   = req && !nstart && !store;
        if (k == m_end && iq.size() > 0) begin
            start(1'b0, iq.pop_front());
        end else if (last || idle) begin
            if (last) idn = 1;
            if (pv) start(prs, pdata);
            else if (nstart) start(rs, data);
        end
        if (drain) pv = 0;
        if (store) begin pv = 1; prs = rs; pdata = data; end
        ovf = oset ? 1 : (ce ? 0 : ovf);
        gp = go; cp = clr; on_m = on; blon_m = blon;
        k++;
    endtask

    task automatic tick();
        lcd_reg_i = {on, blon, junk[17:0], clr, go, rs, junk[18], data};
        rst_i = rst;
        @(negedge clk);
        if (mval) model_check();
        if (lcd_en_o && !en_prev) en_rises++;
        en_prev = lcd_en_o;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic go_pulse(input logic r, input logic [7:0] d);
        rs = r; data = d; go = 1; tick(); go = 0;
    endtask

    initial begin
        lcd_reg_i = '0; rst_i = 1'b1;
        @(posedge clk); #1;
        // 1: reset and init
        rst = 1; run(2); rst = 0;
        run(90);
        chk("init_done", {31'd0, status_o[3]}, 32'd1);
        chk("idle_busy", {31'd0, status_o[0]}, 32'd0);
        // 2: one data write with ON
        on = 1; rs = 1; data = 8'h41; tick();
        go = 1; run(20); go = 0; run(2);
        chk("on_set", {31'd0, lcd_on_o}, 32'd1);
        // 3: back-to-back, pending, overflow, clear
        go_pulse(1'b1, 8'h11); run(2);
        go_pulse(1'b1, 8'h22); run(2);
        chk("pending", {31'd0, status_o[1]}, 32'd1);
        go_pulse(1'b1, 8'h33); run(1);
        chk("ovf_set", {31'd0, status_o[2]}, 32'd1);
        run(30);
        clr = 1; run(2); clr = 0;
        chk("ovf_clr", {31'd0, status_o[2]}, 32'd0);
        run(10);
        // 4: long and short waits
        go_pulse(1'b0, 8'h01); run(32);
        go_pulse(1'b0, 8'h04); run(20);
        // 5: reset during EN pulse
        go_pulse(1'b0, 8'h02); go_pulse(1'b1, 8'h55);
        for (int i = 0; i < 40 && !lcd_en_o; i++) tick();
        chk("en_seen", {31'd0, lcd_en_o}, 32'd1);
        rst = 1; tick(); rst = 0;
        chk("rst_en", {31'd0, lcd_en_o}, 32'd0);
        chk("rst_stat", status_o, 32'd1);
        run(95);
        // 6: GO held, GO high across reset release
        en_rises = 0;
        rs = 1; data = 8'h7A; go = 1; run(50); go = 0; run(5);
        chk("held_once", en_rises, 32'd1);
        go = 1; rst = 1; tick(); rst = 0;
        run(100);
        chk("no_xfer", {31'd0, status_o[0]}, 32'd0);
        go = 0; tick(); go_pulse(1'b1, 8'h5A); run(20);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int sel;
            if ($urandom_range(0, 5) == 0) go = ~go;
            if ($urandom_range(0, 19) == 0) clr = ~clr;
            if ($urandom_range(0, 9) == 0) on = ~on;
            if ($urandom_range(0, 9) == 0) blon = ~blon;
            rst  = ($urandom_range(0, 499) == 0);
            rs   = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 5);
            data = (sel < 4) ? 8'(sel) : 8'($urandom_range(0, 255));
            junk = 19'($urandom);
            tick();
        end
        rst = 0; go = 0; run(150);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
